reg_access_arbiter: RTL and testbench
=====================================

// Module: reg_access_arbiter
// PURPOSE
//  Shares one 16-bit FunSel-controlled Register among NUM_REQ requesters.
//  Round-robin arbitration picks one request, issues it as a single-cycle E pulse, and returns the resulting Q to the winner.
//  Sits between the control unit's micro-op sources and one shared Register instance.
//  Guarantees E is never held high for more than one cycle, so inc/dec fire exactly once.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  WIDTH    16  register data width
//  ID_W     2   requester index width, = clog2(NUM_REQ)
// PORTS
//  Clock      in   1              single clock; all state changes on rising edge
//  Reset      in   1              synchronous, active-low reset
//  Req        in   NUM_REQ        per-requester request; held until its Grant
//  ReqFunSel  in   3*NUM_REQ      per-requester FunSel code, slice k = [3k+2:3k]
//  ReqData    in   WIDTH*NUM_REQ  per-requester I operand, slice k
//  Grant      out  NUM_REQ        one-hot, 1-cycle pulse: request k consumed
//  RegE       out  1              to Register E
//  RegFunSel  out  3              to Register FunSel
//  RegI       out  WIDTH          to Register I
//  RegQ       in   WIDTH          from Register Q
//  RspValid   out  1              1-cycle pulse: RspData valid
//  RspId      out  ID_W           index of the requester the response belongs to
//  RspData    out  WIDTH          Register Q after the op
//  Busy       out  1              high in ISSUE or CAPTURE
// BEHAVIOUR
//  Reset (Reset==0 at edge):
//   - State IDLE; all outputs 0; RR pointer = NUM_REQ-1, so requester 0 wins first.
//  FSM (all outputs registered):
//   - IDLE: if |Req, latch winner w, ReqFunSel[w], ReqData[w]; go ISSUE. Else stay.
//   - ISSUE (1 cycle): RegE=1, Grant[w]=1, RegFunSel/RegI = latched values; go CAPTURE.
//   - CAPTURE (1 cycle): RegE=0, RspValid=1, RspId=w, RspData=RegQ sampled this cycle.
//     If |Req (excluding none), arbitrate again and go ISSUE; else go IDLE.
//  Timing and throughput:
//   - Req seen at edge T -> Grant/RegE in cycle T+1 -> RspValid in T+2.
//   - Back-to-back ops: one op per 2 cycles.
//  Arbitration:
//   - Round-robin, search starts at pointer+1 mod NUM_REQ.
//   - Pointer updates to w on every grant.
//   - Ties are impossible; a lone requester wins every slot.
//  Handshake:
//   - Requester drops Req in the cycle after Grant.
//   - Req still high at the CAPTURE edge counts as a new request.
//   - ReqFunSel/ReqData sampled only at the arbitration edge; later changes are ignored.
//  Outputs outside their active cycle:
//   - RegE, Grant, RspValid are 0.
//   - RegFunSel/RegI hold their last values.
//   - RspId/RspData hold until the next RspValid.
//  FunSel codes pass through unchanged (000 dec … 111 sign-ext low); no illegal codes.
//  Reset mid-op:
//   - Reset in ISSUE or CAPTURE -> next cycle IDLE, RegE=0.
//   - Pending response dropped; no RspValid.
//  Req deasserted before Grant: the already-latched op still completes; that is legal only from CAPTURE/IDLE sampling.
// STRUCTURE
//  Package reg_ctrl_pkg:
//   - FunSel constants FS_DEC=3'b000, FS_INC, FS_LOAD, FS_CLR, FS_WLO_CLR, FS_WLO, FS_WHI, FS_SEXT.
//   - FSM state encoding S_IDLE=2'd0, S_ISSUE=2'd1, S_CAPTURE=2'd2.
//  Sub-module rr_arbiter:
//   - Combinational winner select from Req and pointer.
//   - Registered pointer with enable.
//   - Outputs one-hot grant and encoded index.
//  Top: FSM, operand mux/latch, response register.
// TESTING
//  1. Reset low 2 cycles then high, no Req -> all outputs 0, Busy=0 indefinitely.
//  2. Req[2] with FS_LOAD, data 16'hBEEF -> next cycle Grant=4'b0100, RegE=1, RegFunSel=010;
//     following cycle RspValid=1, RspId=2, RspData=16'hBEEF.
//  3. Req=4'b1111 held, all FS_INC from Q=0 -> grants 0,1,2,3,0 every 2 cycles;
//     RspData 1,2,3,4,5; RegE never high 2 cycles in a row.
//  4. Req[1] FS_SEXT data 16'h0080 then Req[3] FS_WHI data 16'h1200 ->
//     RspData 16'hFF80, then 16'h1280.
//  5. Reset low during ISSUE -> next cycle RegE=0, no RspValid;
//     pointer reset, so the next Req=4'b1010 grants 1.
//  6. ReqData changed the cycle after arbitration -> RegI keeps the originally sampled value.

Source files
------------

// File: rtl/reg_access_arbiter_pkg.sv
// Shared constants and types for the register access arbiter.
// Covers the FunSel code set and the FSM state encoding.
package reg_ctrl_pkg;

  localparam int FUNSEL_W = 3;

  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_WLO_CLR = 3'b100;
  localparam logic [2:0] FS_WLO     = 3'b101;
  localparam logic [2:0] FS_WHI     = 3'b110;
  localparam logic [2:0] FS_SEXT    = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  function automatic logic state_busy(input state_e s);
    return (s == S_ISSUE) || (s == S_CAPTURE);
  endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side and register-side signals of the arbiter bundled together.
// slave = arbiter view, master = view of whatever drives the requests and the register Q.
interface reg_access_arbiter_if
  import reg_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]          req;
  logic [FUNSEL_W*NUM_REQ-1:0] req_fun_sel;
  logic [WIDTH*NUM_REQ-1:0]    req_data;
  logic [NUM_REQ-1:0]          grant;
  logic                        reg_e;
  logic [FUNSEL_W-1:0]         reg_fun_sel;
  logic [WIDTH-1:0]            reg_i;
  logic [WIDTH-1:0]            reg_q;
  logic                        rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic [WIDTH-1:0]            rsp_data;
  logic                        busy;

  modport slave (
    input  req, req_fun_sel, req_data, reg_q,
    output grant, reg_e, reg_fun_sel, reg_i, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req, req_fun_sel, req_data, reg_q,
    input  grant, reg_e, reg_fun_sel, reg_i, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/reg_access_arbiter_rr.sv
// Round-robin winner select with a registered last-winner pointer.
// Search starts one past the pointer, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr_en,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] cand_s;

  // First active request found walking upward from pointer+1, wrapping at NUM_REQ.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_any && req[cand_s]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_s;
      end else begin
        gnt_any = gnt_any;
      end
    end
    if (gnt_any) begin
      gnt_onehot = NUM_REQ'(1) << gnt_idx;
    end else begin
      gnt_onehot = '0;
    end
  end

  // Pointer follows the winner whenever the owner consumes the arbitration.
  always_comb begin
    if (ptr_en && gnt_any) begin
      ptr_d = gnt_idx;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset value makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one FunSel-controlled register among NUM_REQ requesters.
// Each op is a single-cycle E pulse; the resulting Q is returned to the winner next cycle.
module reg_access_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  reg_access_arbiter_if.slave   bus
);

  state_e               state_q;
  state_e               state_d;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   grant_d;
  logic                 reg_e_q;
  logic                 reg_e_d;
  logic [FUNSEL_W-1:0]  reg_fun_sel_q;
  logic [FUNSEL_W-1:0]  reg_fun_sel_d;
  logic [WIDTH-1:0]     reg_i_q;
  logic [WIDTH-1:0]     reg_i_d;
  logic                 rsp_valid_q;
  logic                 rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q;
  logic [ID_W-1:0]      rsp_id_d;
  logic [WIDTH-1:0]     rsp_hold_q;
  logic [WIDTH-1:0]     rsp_hold_d;
  logic [ID_W-1:0]      win_id_q;
  logic [ID_W-1:0]      win_id_d;
  logic                 busy_q;
  logic                 busy_d;

  logic                 arb_en_s;
  logic [NUM_REQ-1:0]   arb_onehot_s;
  logic [ID_W-1:0]      arb_idx_s;
  logic                 arb_any_s;
  logic [FUNSEL_W-1:0]  sel_fun_sel_s;
  logic [WIDTH-1:0]     sel_data_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk        (Clock),
    .rst_n      (Reset),
    .req        (bus.req),
    .ptr_en     (arb_en_s),
    .gnt_onehot (arb_onehot_s),
    .gnt_idx    (arb_idx_s),
    .gnt_any    (arb_any_s)
  );

  // Operand slices of the current arbitration winner.
  always_comb begin
    sel_fun_sel_s = bus.req_fun_sel[FUNSEL_W*arb_idx_s +: FUNSEL_W];
    sel_data_s    = bus.req_data[WIDTH*arb_idx_s +: WIDTH];
  end

  // Next-state and next-output logic; issuing an op latches the winner's operands.
  always_comb begin
    state_d       = state_q;
    grant_d       = '0;
    reg_e_d       = 1'b0;
    reg_fun_sel_d = reg_fun_sel_q;
    reg_i_d       = reg_i_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_hold_d    = rsp_hold_q;
    win_id_d      = win_id_q;
    arb_en_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_any_s) begin
          arb_en_s      = 1'b1;
          grant_d       = arb_onehot_s;
          reg_e_d       = 1'b1;
          reg_fun_sel_d = sel_fun_sel_s;
          reg_i_d       = sel_data_s;
          win_id_d      = arb_idx_s;
          state_d       = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = win_id_q;
        state_d     = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_hold_d = bus.reg_q;
        if (arb_any_s) begin
          arb_en_s      = 1'b1;
          grant_d       = arb_onehot_s;
          reg_e_d       = 1'b1;
          reg_fun_sel_d = sel_fun_sel_s;
          reg_i_d       = sel_data_s;
          win_id_d      = arb_idx_s;
          state_d       = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = state_busy(state_d);
  end

  // State and output registers; reset also drops any in-flight response.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      reg_e_q       <= 1'b0;
      reg_fun_sel_q <= '0;
      reg_i_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_hold_q    <= '0;
      win_id_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      reg_e_q       <= reg_e_d;
      reg_fun_sel_q <= reg_fun_sel_d;
      reg_i_q       <= reg_i_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_hold_q    <= rsp_hold_d;
      win_id_q      <= win_id_d;
      busy_q        <= busy_d;
    end
  end

  // Q only reflects the op during CAPTURE, so the live value is forwarded then and held after.
  assign bus.rsp_data    = rsp_valid_q ? bus.reg_q : rsp_hold_q;
  assign bus.grant       = grant_q;
  assign bus.reg_e       = reg_e_q;
  assign bus.reg_fun_sel = reg_fun_sel_q;
  assign bus.reg_i       = reg_i_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural model of the shared register.
// Expected values are hand-computed constants.
module tb_reg_access_arbiter;
  import reg_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] q_m = 16'h0000;
  logic        prev_e = 1'b0;
  int          errors = 0;
  int          checks = 0;

  reg_access_arbiter_if #(.NUM_REQ(4), .WIDTH(16), .ID_W(2)) bus ();

  reg_access_arbiter #(.NUM_REQ(4), .WIDTH(16), .ID_W(2)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared 16-bit register.
  always @(posedge clk) begin
    if (bus.reg_e) begin
      case (bus.reg_fun_sel)
        FS_DEC:     q_m <= q_m - 16'd1;
        FS_INC:     q_m <= q_m + 16'd1;
        FS_LOAD:    q_m <= bus.reg_i;
        FS_CLR:     q_m <= 16'h0000;
        FS_WLO_CLR: q_m <= {8'h00, bus.reg_i[7:0]};
        FS_WLO:     q_m <= {q_m[15:8], bus.reg_i[7:0]};
        FS_WHI:     q_m <= {bus.reg_i[15:8], q_m[7:0]};
        default:    q_m <= {{8{bus.reg_i[7]}}, bus.reg_i[7:0]};
      endcase
    end
  end
  assign bus.reg_q = q_m;

  // E must never stay high for two consecutive cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(bus.reg_e && prev_e)) else begin
        errors++;
        $error("FAIL rege_double: reg_e=%0b prev=%0b expected not both 1", bus.reg_e, prev_e);
      end
    end
    prev_e <= bus.reg_e;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]  exp_id[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [15:0] exp_d [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};

  initial begin
    bus.req         = 4'b0000;
    bus.req_fun_sel = 12'h000;
    bus.req_data    = 64'h0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_rege", 32'(bus.reg_e), 32'h0);
    check("rst_funsel", 32'(bus.reg_fun_sel), 32'h0);
    check("rst_regi", 32'(bus.reg_i), 32'h0);
    check("rst_rspv", 32'(bus.rsp_valid), 32'h0);
    check("rst_rspid", 32'(bus.rsp_id), 32'h0);
    check("rst_rspdata", 32'(bus.rsp_data), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("idle_grant", 32'(bus.grant), 32'h0);

    // 2: single LOAD from requester 2
    bus.req_fun_sel[8:6] = FS_LOAD;
    bus.req_data[47:32]  = 16'hBEEF;
    bus.req              = 4'b0100;
    step();
    check("t2_grant", 32'(bus.grant), 32'h4);
    check("t2_rege", 32'(bus.reg_e), 32'h1);
    check("t2_funsel", 32'(bus.reg_fun_sel), 32'h2);
    check("t2_regi", 32'(bus.reg_i), 32'hBEEF);
    check("t2_busy_issue", 32'(bus.busy), 32'h1);
    bus.req = 4'b0000;
    step();
    check("t2_rspv", 32'(bus.rsp_valid), 32'h1);
    check("t2_rspid", 32'(bus.rsp_id), 32'h2);
    check("t2_rspdata", 32'(bus.rsp_data), 32'hBEEF);
    check("t2_rege_off", 32'(bus.reg_e), 32'h0);
    check("t2_grant_off", 32'(bus.grant), 32'h0);
    check("t2_busy_cap", 32'(bus.busy), 32'h1);
    step();
    check("t2_rspv_off", 32'(bus.rsp_valid), 32'h0);
    check("t2_rspdata_hold", 32'(bus.rsp_data), 32'hBEEF);
    check("t2_rspid_hold", 32'(bus.rsp_id), 32'h2);
    check("t2_funsel_hold", 32'(bus.reg_fun_sel), 32'h2);
    check("t2_busy_idle", 32'(bus.busy), 32'h0);

    // 3: clear via requester 3, then all four INC held
    bus.req_fun_sel[11:9] = FS_CLR;
    bus.req               = 4'b1000;
    step();
    check("t3_clr_grant", 32'(bus.grant), 32'h8);
    bus.req = 4'b0000;
    step();
    check("t3_clr_data", 32'(bus.rsp_data), 32'h0);
    step();
    bus.req_fun_sel = {FS_INC, FS_INC, FS_INC, FS_INC};
    bus.req         = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_grant", 32'(bus.grant), 32'(exp_g[k]));
      check("t3_rege", 32'(bus.reg_e), 32'h1);
      if (k == 4) bus.req = 4'b0000;
      step();
      check("t3_rspv", 32'(bus.rsp_valid), 32'h1);
      check("t3_rspid", 32'(bus.rsp_id), 32'(exp_id[k]));
      check("t3_rspdata", 32'(bus.rsp_data), 32'(exp_d[k]));
    end
    step();
    check("t3_busy_idle", 32'(bus.busy), 32'h0);

    // 4: SEXT from 1, then back-to-back WHI from 3
    bus.req_fun_sel[5:3] = FS_SEXT;
    bus.req_data[31:16]  = 16'h0080;
    bus.req              = 4'b0010;
    step();
    check("t4_grant1", 32'(bus.grant), 32'h2);
    check("t4_funsel1", 32'(bus.reg_fun_sel), 32'h7);
    bus.req_fun_sel[11:9] = FS_WHI;
    bus.req_data[63:48]   = 16'h1200;
    bus.req               = 4'b1000;
    step();
    check("t4_rspid1", 32'(bus.rsp_id), 32'h1);
    check("t4_rspdata1", 32'(bus.rsp_data), 32'hFF80);
    step();
    check("t4_grant3", 32'(bus.grant), 32'h8);
    check("t4_regi3", 32'(bus.reg_i), 32'h1200);
    bus.req = 4'b0000;
    step();
    check("t4_rspid3", 32'(bus.rsp_id), 32'h3);
    check("t4_rspdata3", 32'(bus.rsp_data), 32'h1280);
    step();

    // 5: reset during ISSUE; pointer returns to NUM_REQ-1
    bus.req_fun_sel[8:6] = FS_INC;
    bus.req              = 4'b0100;
    step();
    check("t5_grant2", 32'(bus.grant), 32'h4);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    step();
    check("t5_rege", 32'(bus.reg_e), 32'h0);
    check("t5_rspv", 32'(bus.rsp_valid), 32'h0);
    check("t5_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    step();
    check("t5_rspv_after", 32'(bus.rsp_valid), 32'h0);
    bus.req_fun_sel[5:3] = FS_LOAD;
    bus.req_data[31:16]  = 16'h00AA;
    bus.req_fun_sel[11:9] = FS_LOAD;
    bus.req_data[63:48]  = 16'h0BBB;
    bus.req              = 4'b1010;
    step();
    check("t5_grant_ptr", 32'(bus.grant), 32'h2);
    bus.req = 4'b0000;
    step();
    check("t5_rspid", 32'(bus.rsp_id), 32'h1);
    check("t5_rspdata", 32'(bus.rsp_data), 32'h00AA);
    step();

    // 6: operand change after arbitration is ignored
    bus.req_fun_sel[2:0] = FS_LOAD;
    bus.req_data[15:0]   = 16'h1234;
    bus.req              = 4'b0001;
    step();
    check("t6_grant0", 32'(bus.grant), 32'h1);
    check("t6_regi", 32'(bus.reg_i), 32'h1234);
    bus.req_data[15:0] = 16'h5555;
    bus.req            = 4'b0000;
    step();
    check("t6_regi_keep", 32'(bus.reg_i), 32'h1234);
    check("t6_rspdata", 32'(bus.rsp_data), 32'h1234);
    step();
    check("t6_regi_idle", 32'(bus.reg_i), 32'h1234);
    check("t6_busy_idle", 32'(bus.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
